// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared encodings for the multiply/divide unit
package mdu_pkg;

  localparam int WIDTH_DEFAULT = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_MADD  = 3'd2,
    OP_MADDU = 3'd3,
    OP_MSUB  = 3'd4,
    OP_MSUBU = 3'd5,
    OP_DIV   = 3'd6,
    OP_DIVU  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_ACC  = 3'd2,
    ST_DIV  = 3'd3,
    ST_FIX  = 3'd4,
    ST_DONE = 3'd5
  } state_e;

endpackage

// File: rtl/mdu_if.sv
// rtl/mdu_if.sv - request/response bundle between pipeline and mdu
interface mdu_if import mdu_pkg::*; #(parameter int WIDTH = WIDTH_DEFAULT);
  logic                 start_i;
  logic [2:0]           op_i;
  logic [WIDTH-1:0]     opdata1_i;
  logic [WIDTH-1:0]     opdata2_i;
  logic [2*WIDTH-1:0]   hilo_i;
  logic                 annul_i;
  logic [2*WIDTH-1:0]   result_o;
  logic                 ready_o;
  logic                 dz_o;
  logic                 stallreq_o;

  modport master (
    output start_i, op_i, opdata1_i, opdata2_i, hilo_i, annul_i,
    input  result_o, ready_o, dz_o, stallreq_o
  );

  modport slave (
    input  start_i, op_i, opdata1_i, opdata2_i, hilo_i, annul_i,
    output result_o, ready_o, dz_o, stallreq_o
  );
endinterface

// File: rtl/mdu_div_iter.sv
// rtl/mdu_div_iter.sv - one restoring-divide step on unsigned magnitudes
module mdu_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q
);
  logic [WIDTH:0] w_shift;

  // Partial remainder stays below the divisor, so a successful subtract fits WIDTH bits.
  assign w_shift = {i_rem, i_bit};
  assign o_q     = (w_shift >= {1'b0, i_divisor});
  assign o_rem   = o_q ? (w_shift[WIDTH-1:0] - i_divisor) : w_shift[WIDTH-1:0];
endmodule

// File: rtl/mdu.sv
// rtl/mdu.sv - multi-cycle multiply / multiply-accumulate / restoring divide unit
module mdu import mdu_pkg::*; #(
  parameter int WIDTH         = WIDTH_DEFAULT,
  parameter bit SIGNED_DIV_EN = 1'b1
) (
  input logic   clk,
  input logic   rst,
  mdu_if.slave  bus
);
  state_e               r_state;
  op_e                  r_op;
  logic [WIDTH-1:0]     r_a, r_b, r_rem, r_cnt;
  logic [2*WIDTH-1:0]   r_prod, r_result;
  logic                 r_neg_q, r_neg_r, r_ready, r_dz;

  logic                 w_accept, w_signed, w_s1, w_s2, w_is_div, w_qbit;
  logic [WIDTH-1:0]     w_mag1, w_mag2, w_rem_next;
  logic [2*WIDTH-1:0]   w_prod_mag, w_prod;

  assign w_accept = bus.start_i && !bus.annul_i && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_is_div = (bus.op_i[2:1] == 2'b11);
  assign w_signed = !bus.op_i[0] && ((bus.op_i != 3'(OP_DIV)) || SIGNED_DIV_EN);
  assign w_s1     = w_signed && bus.opdata1_i[WIDTH-1];
  assign w_s2     = w_signed && bus.opdata2_i[WIDTH-1];
  assign w_mag1   = w_s1 ? -bus.opdata1_i : bus.opdata1_i;
  assign w_mag2   = w_s2 ? -bus.opdata2_i : bus.opdata2_i;

  assign w_prod_mag = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};
  assign w_prod     = r_neg_q ? -w_prod_mag : w_prod_mag;

  // r_a carries the dividend bits out and the quotient bits in during DIV.
  mdu_div_iter #(.WIDTH(WIDTH)) u_div_iter (
    .i_rem     (r_rem),
    .i_bit     (r_a[WIDTH-1]),
    .i_divisor (r_b),
    .o_rem     (w_rem_next),
    .o_q       (w_qbit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_op     <= OP_MULT;
      r_a      <= '0;
      r_b      <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_prod   <= '0;
      r_result <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_ready  <= 1'b0;
      r_dz     <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_dz    <= 1'b0;
      if (bus.annul_i) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE, ST_DONE: begin
            if (bus.start_i) begin
              r_op    <= op_e'(bus.op_i);
              r_a     <= w_mag1;
              r_b     <= w_mag2;
              r_rem   <= '0;
              r_cnt   <= '0;
              r_neg_q <= w_s1 ^ w_s2;
              r_neg_r <= w_s1;
              if (!w_is_div) begin
                r_state <= ST_MUL;
              end else if (bus.opdata2_i == '0) begin
                r_result <= '0;
                r_ready  <= 1'b1;
                r_dz     <= 1'b1;
                r_state  <= ST_DONE;
              end else begin
                r_state <= ST_DIV;
              end
            end else begin
              r_state <= ST_IDLE;
            end
          end
          ST_MUL: begin
            r_prod <= w_prod;
            if (r_op inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU}) begin
              r_state <= ST_ACC;
            end else begin
              r_result <= w_prod;
              r_ready  <= 1'b1;
              r_state  <= ST_DONE;
            end
          end
          ST_ACC: begin
            r_result <= (r_op inside {OP_MSUB, OP_MSUBU}) ? bus.hilo_i - r_prod
                                                          : bus.hilo_i + r_prod;
            r_ready  <= 1'b1;
            r_state  <= ST_DONE;
          end
          ST_DIV: begin
            r_a   <= {r_a[WIDTH-2:0], w_qbit};
            r_rem <= w_rem_next;
            if (r_cnt == WIDTH'(WIDTH - 1)) begin
              r_cnt   <= '0;
              r_state <= ST_FIX;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_FIX: begin
            r_result <= {(r_neg_r ? -r_rem : r_rem), (r_neg_q ? -r_a : r_a)};
            r_ready  <= 1'b1;
            r_state  <= ST_DONE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.result_o   = r_result;
  assign bus.ready_o    = r_ready;
  assign bus.dz_o       = r_dz;
  assign bus.stallreq_o = !rst && (w_accept ||
                          (r_state inside {ST_MUL, ST_ACC, ST_DIV, ST_FIX}));
endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - scoreboard bench for mdu with directed vectors
module tb_mdu;
  import mdu_pkg::*;
  localparam int W = 32;

  typedef struct {
    logic [2*W-1:0] res;
    logic           dz;
    int             cyc;
    string          name;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mdu_if #(.WIDTH(W)) bus ();
  mdu #(.WIDTH(W), .SIGNED_DIV_EN(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));

  exp_t           sb[$];
  exp_t           m_e;
  int             cyc = 0;
  int             checks = 0;
  int             failures = 0;
  logic [2*W-1:0] last_res = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.ready_o) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_ready: got result=%h dz=%b, required no ready", bus.result_o, bus.dz_o);
      end else begin
        m_e = sb.pop_front();
        if (bus.result_o !== m_e.res) begin
          failures++;
          $display("FAIL %s result: got %h, required %h", m_e.name, bus.result_o, m_e.res);
        end
        checks++;
        if (bus.dz_o !== m_e.dz) begin
          failures++;
          $display("FAIL %s dz: got %b, required %b", m_e.name, bus.dz_o, m_e.dz);
        end
        checks++;
        if (cyc != m_e.cyc) begin
          failures++;
          $display("FAIL %s latency: ready at cycle %0d, required %0d", m_e.name, cyc, m_e.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [2*W-1:0] got, input logic [2*W-1:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // Called at a negedge; the following posedge is the accept edge.
  task automatic drive_start(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [2*W-1:0] hilo, input logic [2*W-1:0] res, input logic dz,
                             input int lat, input string name, input bit push);
    exp_t e;
    bus.start_i   = 1'b1;
    bus.op_i      = op;
    bus.opdata1_i = a;
    bus.opdata2_i = b;
    bus.hilo_i    = hilo;
    if (push) begin
      e.res = res; e.dz = dz; e.cyc = cyc + lat; e.name = name;
      sb.push_back(e);
      last_res = res;
    end
    #1;
    check({name, "_stallreq"}, {63'd0, bus.stallreq_o}, 64'd1);
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] hilo, input logic [2*W-1:0] res, input logic dz,
                       input int lat, input string name);
    @(negedge clk);
    drive_start(op, a, b, hilo, res, dz, lat, name, 1'b1);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s timeout: %0d results outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int t;
    int n;
    bus.start_i = 1'b0; bus.op_i = '0; bus.opdata1_i = '0; bus.opdata2_i = '0;
    bus.hilo_i = '0; bus.annul_i = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_result", bus.result_o, 64'd0);
    check("reset_ready", {63'd0, bus.ready_o}, 64'd0);
    check("reset_dz", {63'd0, bus.dz_o}, 64'd0);
    check("reset_stall", {63'd0, bus.stallreq_o}, 64'd0);
    rst = 1'b0;

    issue(OP_MULT,  32'hFFFFFFFD, 32'd5, 64'd0, 64'hFFFFFFFF_FFFFFFF1, 1'b0, 2, "mult_neg");
    wait_done("mult_neg");
    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0, 64'hFFFFFFFE_00000001, 1'b0, 2, "multu_max");
    wait_done("multu_max");
    issue(OP_MADDU, 32'd1, 32'd1, 64'h00000000_FFFFFFFF, 64'h00000001_00000000, 1'b0, 3, "maddu_carry");
    wait_done("maddu_carry");
    issue(OP_MSUB,  32'd2, 32'd3, 64'd0, 64'hFFFFFFFF_FFFFFFFA, 1'b0, 3, "msub");
    wait_done("msub");
    issue(OP_MADD,  32'hFFFFFFFE, 32'd3, 64'd10, 64'd4, 1'b0, 3, "madd_neg");
    wait_done("madd_neg");
    issue(OP_DIVU,  32'd5, 32'd0, 64'd0, 64'd0, 1'b1, 1, "divu_zero");
    wait_done("divu_zero");
    issue(OP_DIV,   32'hFFFFFFF9, 32'd2, 64'd0, 64'hFFFFFFFF_FFFFFFFD, 1'b0, W + 2, "div_neg7_2");
    wait_done("div_neg7_2");
    issue(OP_DIVU,  32'd100, 32'd7, 64'd0, 64'h00000002_0000000E, 1'b0, W + 2, "divu_100_7");
    wait_done("divu_100_7");
    issue(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 64'd0, 64'h00000000_80000000, 1'b0, W + 2, "div_wrap");
    wait_done("div_wrap");
    issue(OP_DIV,   32'd7, 32'hFFFFFFFE, 64'd0, 64'h00000001_FFFFFFFD, 1'b0, W + 2, "div_7_neg2");
    wait_done("div_7_neg2");
    issue(OP_DIVU,  32'hFFFFFFFF, 32'd1, 64'd0, 64'h00000000_FFFFFFFF, 1'b0, W + 2, "divu_max_1");
    wait_done("divu_max_1");

    // Annul mid-divide, then restart in the very next cycle.
    @(negedge clk);
    drive_start(OP_DIVU, 32'd100, 32'd7, 64'd0, 64'd0, 1'b0, 0, "annul_div", 1'b0);
    t = cyc;
    while (cyc < t + 9) @(negedge clk);
    bus.annul_i = 1'b1;
    @(negedge clk);
    bus.annul_i = 1'b0;
    check("annul_result_held", bus.result_o, last_res);
    check("annul_no_ready", {63'd0, bus.ready_o}, 64'd0);
    drive_start(OP_MULTU, 32'd6, 32'd7, 64'd0, 64'd42, 1'b0, 2, "after_annul", 1'b1);
    wait_done("after_annul");

    // Reset mid-divide while start is also asserted.
    @(negedge clk);
    drive_start(OP_DIVU, 32'd100, 32'd7, 64'd0, 64'd0, 1'b0, 0, "rst_div", 1'b0);
    t = cyc;
    while (cyc < t + 4) @(negedge clk);
    rst = 1'b1;
    bus.start_i = 1'b1;
    bus.op_i = OP_MULT;
    #1;
    check("rst_stall_comb", {63'd0, bus.stallreq_o}, 64'd0);
    @(negedge clk);
    check("rst_result", bus.result_o, 64'd0);
    check("rst_ready", {63'd0, bus.ready_o}, 64'd0);
    rst = 1'b0;
    bus.start_i = 1'b0;
    @(negedge clk);
    check("rst_idle_stall", {63'd0, bus.stallreq_o}, 64'd0);
    repeat (40) @(negedge clk);
    check("rst_result_quiet", bus.result_o, 64'd0);

    // Back-to-back: new start in the DONE cycle of the previous op.
    issue(OP_MULT, 32'hFFFFFFFD, 32'd5, 64'd0, 64'hFFFFFFFF_FFFFFFF1, 1'b0, 2, "b2b_mult");
    n = 0;
    while (!bus.ready_o && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("b2b_ready_seen", {63'd0, bus.ready_o}, 64'd1);
    drive_start(OP_DIVU, 32'd100, 32'd7, 64'd0, 64'h00000002_0000000E, 1'b0, W + 2, "b2b_divu", 1'b1);
    wait_done("b2b_divu");

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter WIDTH, default 32, operand width; result width is 2*WIDTH as {HI,LO}.
REQ-002 Parameter SIGNED_DIV_EN, default 1; when 0, DIV executes as DIVU.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start_i  in  1  request; sampled with op_i, opdata1_i, opdata2_i.
REQ-006 op_i  in  3  MULT=0, MULTU=1, MADD=2, MADDU=3, MSUB=4, MSUBU=5, DIV=6, DIVU=7.
REQ-007 opdata1_i / opdata2_i  in  WIDTH each  multiplicand/dividend, multiplier/divisor.
REQ-008 hilo_i  in  2*WIDTH  forwarded {HI,LO}, consumed by MADD/MSUB.
REQ-009 annul_i  in  1  cancels the operation in flight.
REQ-010 result_o  out  2*WIDTH  {HI,LO}; DIV gives {remainder, quotient}.
REQ-011 ready_o  out  1  one-cycle pulse; result_o valid.
REQ-012 dz_o  out  1  divide-by-zero flag, valid with ready_o.
REQ-013 stallreq_o  out  1  pipeline stall request (combinational).

Function
REQ-014 States: IDLE, MUL, ACC, DIV, FIX, DONE.
REQ-015 Accept: start_i=1 and annul_i=0 in IDLE or DONE (back-to-back allowed); start_i in any other state is ignored.
REQ-016 Transitions from accept:
- MULT/MULTU/MADD*/MSUB* go to MUL.
- DIV/DIVU with opdata2_i != 0 go to DIV.
- DIV/DIVU with opdata2_i == 0 go to DONE.
REQ-017 MUL: register the full 2*WIDTH product; signed ops use magnitude multiply with sign fix; next state is ACC for MADD*/MSUB*, else DONE.
REQ-018 ACC: result = hilo_i + product (MADD*) or hilo_i - product (MSUB*), modulo 2^(2*WIDTH); hilo_i is sampled in this cycle only.
REQ-019 DIV: restoring radix-2 on magnitudes, one quotient bit per cycle, exactly WIDTH cycles; then FIX.
REQ-020 FIX: quotient sign = s1 XOR s2; remainder sign = s1.
REQ-021 Most-negative / -1 wraps: quotient 2^(WIDTH-1), remainder 0, no flag.
REQ-022 Latency from accept edge t (ready_o high in cycle):
- MULT/MULTU: t+2.
- MADD*/MSUB*: t+3.
- DIV/DIVU: t+WIDTH+2.
- Divide-by-zero: t+1, with result_o = 0 and dz_o = 1.
REQ-023 ready_o and dz_o are high only in DONE; result_o holds its value until the next DONE.
REQ-024 stallreq_o = (accept condition) OR state in {MUL, ACC, DIV, FIX}; low in DONE.
REQ-025 annul_i=1: next state IDLE, no ready_o, result_o unchanged; annul_i wins over a simultaneous start_i.
REQ-026 WIDTH-bit iteration counter; no other counter wraps.

Reset
REQ-027 rst=1 sets state IDLE, result_o=0, ready_o=0, dz_o=0, counter=0, stallreq_o=0, including mid-operation; rst overrides start_i.

Structure
REQ-028 Shared package holds the op_i encodings, state encoding and the WIDTH default.
REQ-029 One sub-module, mdu_div_iter: a single restoring-divide step (partial remainder, divisor, quotient bit), instantiated once.

Verification
REQ-030 MULT -3 x 5 -> result_o=0xFFFFFFFF_FFFFFFF1, ready_o at t+2.
REQ-031 MADDU 1 x 1 with hilo_i=0x00000000_FFFFFFFF -> 0x00000001_00000000 at t+3; MSUB 2 x 3 with hilo_i=0 -> 0xFFFFFFFF_FFFFFFFA.
REQ-032 DIV -7 / 2 -> {0xFFFFFFFF, 0xFFFFFFFD} at t+34; DIVU 100 / 7 -> {2, 14}; DIV 0x80000000 / -1 -> {0, 0x80000000}.
REQ-033 DIVU 5 / 0 -> dz_o=1, result_o=0, ready_o at t+1.
REQ-034 annul_i at t+10 of DIV -> no ready_o, result_o unchanged; start_i next cycle accepted with correct latency.
REQ-035 rst at t+5 of DIV -> all outputs 0, IDLE; start_i with annul_i=0 in the DONE cycle -> back-to-back results with no gap.
